rr_mux_4_1_v: RTL
=================

// Module: rr_mux_4_1_v
// PURPOSE
//   4-to-1 round-robin arbitrating multiplexer; the collecting end of the 1:4 demux path.
//   Merges four valid/ready source channels into one registered output stream.
//   Tags each output beat with a 4-bit one-hot o_sel_code, so a downstream 1:4 demux
//   can route the beat back out to the matching lane.
// PARAMETERS
//   DATA_W     8   width of each channel's data word
//   BURST_LEN  4   max consecutive beats granted to one channel while others are waiting (>=1)
// PORTS
//   i_clk       in   1          single clock; all state updates on rising edge
//   i_rst       in   1          synchronous reset, active-high
//   i_valid     in   4          per-channel beat valid; bit k = channel k
//   i_data      in   4*DATA_W   channel k data at [k*DATA_W +: DATA_W]
//   o_ready     out  4          per-channel accept; beat on channel k transfers when i_valid[k] & o_ready[k]
//   o_valid     out  1          output beat valid (registered)
//   o_data      out  DATA_W     output beat data (registered)
//   o_sel_code  out  4          one-hot source channel of the current output beat (registered)
//   i_ready     in   1          downstream accept; output beat transfers when o_valid & i_ready
// BEHAVIOUR
//   Reset (i_rst=1 at edge):
//     o_valid=0, o_data=0, o_sel_code=4'b0000, last-grant pointer=3, burst count=0.
//     o_ready=0 during reset. A pending output beat is dropped.
//   Load condition: load = ~o_valid | i_ready. The output register can take a new beat this cycle.
//   Grant (combinational, from registered pointer/count and i_valid):
//     - Sticky: if burst count < BURST_LEN and i_valid[ptr], grant ptr.
//     - Otherwise rotate: first k with i_valid[k] searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
//     - No i_valid bit set -> no grant.
//   o_ready[k] = load & grant[k] & ~i_rst. At most one o_ready bit is high; o_ready[k] is
//     never high while i_valid[k]=0.
//   On a transfer from channel k:
//     - o_data <= channel k data; o_sel_code <= 1<<k; o_valid <= 1.
//     - If k==ptr: count <= count+1. Else: ptr <= k, count <= 1.
//   On load with no grant: o_valid <= 0; o_data and o_sel_code hold their last values.
//   Without load (o_valid & ~i_ready): o_valid, o_data, o_sel_code, ptr and count all hold.
//   Latency: an accepted input beat appears on o_data exactly 1 cycle later.
//   Throughput: 1 beat/cycle while i_ready=1.
//   Burst count saturation:
//     - At count==BURST_LEN the sticky rule fails and rotation begins at ptr+1.
//     - If ptr is the only requester it is regranted and count restarts at 1.
//   Simultaneous events: output transfer and new input accept in the same cycle are a
//     normal pipelined handoff; no bubble is inserted.
//   Stable output: o_data and o_sel_code never change while o_valid=1 and i_ready=0.
//   Arithmetic: ptr is 2-bit and wraps 3->0. Count width is clog2(BURST_LEN+1) and never
//     exceeds BURST_LEN.
// TESTING
//   1 Reset: hold i_rst 2 cycles with i_valid=4'hF -> o_valid=0, o_sel_code=0, o_ready=0;
//     first grant after release is ch0.
//   2 Single source: ch2 streams 0x10..0x17, i_ready=1 -> o_data matches 1 cycle later,
//     o_sel_code=4'b0100 throughout, no gaps.
//   3 Fairness: i_valid=4'hF constant, i_ready=1, BURST_LEN=4 -> grants ch0 x4, ch1 x4,
//     ch2 x4, ch3 x4, then ch0 again.
//   4 Backpressure: i_ready=0 for 5 cycles mid-stream -> o_data/o_sel_code frozen,
//     o_ready=0, no beat lost or duplicated.
//   5 Rotation skip: only ch1 and ch3 valid, ch1 burst hits limit -> next grant ch3,
//     then back to ch1.
//   6 Reset mid-burst: i_rst at beat 2 of a ch1 burst -> o_valid=0 next cycle;
//     pointer=3, so ch0 has priority afterwards.

Source files
------------

// File: rtl/rr_mux_4_1_v_if.sv
// Four-lane collecting bus: per-lane valid/ready/data in, one tagged stream out.
// The slave modport is the arbitrating mux; master is the agent driving the lanes and sink.
interface rr_mux_4_1_v_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          i_valid;
    logic [4*DATA_W-1:0] i_data;
    logic [3:0]          o_ready;
    logic                o_valid;
    logic [DATA_W-1:0]   o_data;
    logic [3:0]          o_sel_code;
    logic                i_ready;

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_sel_code
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_sel_code
    );
endinterface

// File: rtl/rr_mux_4_1_v.sv
// 4:1 round-robin mux with bounded bursts; output beat tagged with a one-hot source code.
// Latency: 1 cycle (registered output), 1 beat/cycle sustained.
// Backpressure: when the output holds an unaccepted beat, all lane readies drop and state freezes.
module rr_mux_4_1_v #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rr_mux_4_1_v_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        ptr;
    logic [CNT_W-1:0]  cnt;
    logic              out_vld;
    logic [DATA_W-1:0] out_dat;
    logic [3:0]        out_sel;

    logic [DATA_W-1:0] lane [4];
    logic              load;
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic              xfer;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            assign lane[g] = bus.i_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign load = ~out_vld | bus.i_ready;

    // A zero count means no burst is in progress (only after reset), so the
    // sticky rule is skipped and rotation starts at ptr+1, giving ch0 first.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        if (cnt != '0 && cnt < CNT_MAX && bus.i_valid[ptr]) begin
            gnt_any = 1'b1;
        end else begin
            for (int j = 1; j <= 4; j++) begin
                cand = ptr + 2'(j);
                if (!gnt_any && bus.i_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign xfer        = load & gnt_any & ~i_rst;
    assign bus.o_ready = xfer ? (4'b0001 << gnt_idx) : 4'b0000;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_sel <= 4'b0000;
            ptr     <= 2'd3;
            cnt     <= '0;
        end else if (load) begin
            if (gnt_any) begin
                out_vld <= 1'b1;
                out_dat <= lane[gnt_idx];
                out_sel <= 4'b0001 << gnt_idx;
                // A saturated pointer regranted as sole requester starts a fresh burst.
                if (gnt_idx == ptr && cnt < CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end else begin
                    ptr <= gnt_idx;
                    cnt <= CNT_ONE;
                end
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    assign bus.o_valid    = out_vld;
    assign bus.o_data     = out_dat;
    assign bus.o_sel_code = out_sel;
endmodule
